// File: rtl/turn_signal_ctrl_if.sv
// Switch inputs and blinker request outputs of the turn signal controller.
// The controller takes the slave view; a driver/monitor takes the master view.
interface turn_signal_ctrl_if;
   logic       leftSwitch;
   logic       rightSwitch;
   logic       hazardSwitch;
   logic       turnSignalLeft;
   logic       turnSignalRight;
   logic [1:0] mode;
   logic       modeChange;

   modport master (
      output leftSwitch,
      output rightSwitch,
      output hazardSwitch,
      input  turnSignalLeft,
      input  turnSignalRight,
      input  mode,
      input  modeChange
   );

   modport slave (
      input  leftSwitch,
      input  rightSwitch,
      input  hazardSwitch,
      output turnSignalLeft,
      output turnSignalRight,
      output mode,
      output modeChange
   );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn signal controller: synchronizes and debounces the three lever/button
// contacts, decodes a requested mode, and runs a 4-state FSM with a minimum
// on-time for LEFT/RIGHT/HAZARD. HAZARD may preempt a running minimum-on timer.
// All outputs are decoded from registers only.
module turn_signal_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MIN_ON_CYCLES   = 8
) (
   input  logic               clk,
   input  logic               reset,
   turn_signal_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2,
      ST_HAZARD = 2'd3
   } state_t;

   // Channel index: 0 = left, 1 = right, 2 = hazard.
   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] MIN_LOAD = 8'(MIN_ON_CYCLES - 1);

   logic [2:0] w_raw;
   logic [2:0] r_meta;
   logic [2:0] r_sync;
   logic [2:0] r_deb;
   logic [7:0] r_cnt [3];

   state_t     r_state;
   state_t     w_state_nxt;
   state_t     w_req;
   logic [7:0] r_timer;
   logic [7:0] w_timer_nxt;
   logic       r_mode_change;

   assign w_raw = {bus.hazardSwitch, bus.rightSwitch, bus.leftSwitch};

   // Two-flop synchronizer for each raw contact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= 3'b000;
         r_sync <= 3'b000;
      end else begin
         r_meta <= w_raw;
         r_sync <= r_meta;
      end
   end

   // Debounce: the debounced level follows the synchronized level only after
   // it has differed for DEBOUNCE_CYCLES consecutive edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_deb <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (r_sync[i] == r_deb[i]) begin
               r_cnt[i] <= 8'd0;
            end else if (r_cnt[i] == DEB_LAST) begin
               r_deb[i] <= r_sync[i];
               r_cnt[i] <= 8'd0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

   // Requested mode: hazard wins; left+right together is treated as no request.
   always_comb begin
      w_req = ST_IDLE;
      if (r_deb[2]) begin
         w_req = ST_HAZARD;
      end else if (r_deb[0] && !r_deb[1]) begin
         w_req = ST_LEFT;
      end else if (!r_deb[0] && r_deb[1]) begin
         w_req = ST_RIGHT;
      end else begin
         w_req = ST_IDLE;
      end
   end

   // Next state and minimum-on timer: a running timer blocks every change
   // except a hazard request; entering an active state restarts the timer.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = 8'd0;
      if (r_timer != 8'd0) begin
         w_timer_nxt = r_timer - 8'd1;
      end else begin
         w_timer_nxt = 8'd0;
      end
      if ((w_req != r_state) && ((r_timer == 8'd0) || (w_req == ST_HAZARD))) begin
         w_state_nxt = w_req;
         if (w_req == ST_IDLE) begin
            w_timer_nxt = 8'd0;
         end else begin
            w_timer_nxt = MIN_LOAD;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State, timer and change-pulse registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_timer       <= 8'd0;
         r_mode_change <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_timer       <= w_timer_nxt;
         r_mode_change <= (w_state_nxt != r_state);
      end
   end

   assign bus.turnSignalLeft  = (r_state == ST_LEFT)  || (r_state == ST_HAZARD);
   assign bus.turnSignalRight = (r_state == ST_RIGHT) || (r_state == ST_HAZARD);
   assign bus.mode            = r_state;
   assign bus.modeChange      = r_mode_change;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Self-checking bench for turn_signal_ctrl: directed scenarios with expected
// edge timing written out explicitly, then randomized switch activity (with
// occasional asynchronous resets) checked against a sample-history model.
module tb_turn_signal_ctrl;
   localparam int DEB = 4;
   localparam int MIN = 8;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   turn_signal_ctrl_if bus ();

   turn_signal_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .MIN_ON_CYCLES   (MIN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // m_hist[k] holds the raw contacts sampled k+1 edges before the current one.
   logic [2:0] m_hist [0:DEB];
   logic [2:0] m_deb;
   int         m_state;   // 0 idle, 1 left, 2 right, 3 hazard
   int         m_entry;   // edge number at which current active state was entered
   int         m_edge;
   bit         m_mc;

   // Model: a level is accepted once the synchronized contact (raw delayed two
   // edges) has disagreed with it for DEB edges in a row; an active state may
   // be left only MIN edges after entry unless hazard is requested.
   always @(posedge clk or negedge reset) begin
      logic [2:0] new_deb;
      int         req;
      bit         all_diff;
      if (!reset) begin
         for (int k = 0; k <= DEB; k++) m_hist[k] = 3'b000;
         m_deb   = 3'b000;
         m_state = 0;
         m_entry = -100000;
         m_edge  = 0;
         m_mc    = 1'b0;
      end else begin
         m_edge = m_edge + 1;
         for (int ch = 0; ch < 3; ch++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= DEB; k++)
               if (m_hist[k][ch] == m_deb[ch]) all_diff = 1'b0;
            new_deb[ch] = all_diff ? ~m_deb[ch] : m_deb[ch];
         end
         if (m_deb[2])                      req = 3;
         else if (m_deb[0] && !m_deb[1])    req = 1;
         else if (!m_deb[0] && m_deb[1])    req = 2;
         else                               req = 0;
         if ((req != m_state) && ((m_edge - m_entry >= MIN) || (req == 3))) begin
            m_state = req;
            m_entry = (req == 0) ? -100000 : m_edge;
            m_mc    = 1'b1;
         end else begin
            m_mc    = 1'b0;
         end
         for (int k = DEB; k >= 1; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = {bus.hazardSwitch, bus.rightSwitch, bus.leftSwitch};
         m_deb = new_deb;
      end
   end

   // Expected {mode, left, right, modeChange} for a given state and pulse.
   function automatic logic [4:0] exp_vec(input int st, input bit mc);
      logic [1:0] m;
      m = 2'(st);
      return {m, (st == 1) || (st == 3), (st == 2) || (st == 3), mc};
   endfunction

   function automatic logic [4:0] obs_vec();
      return {bus.mode, bus.turnSignalLeft, bus.turnSignalRight, bus.modeChange};
   endfunction

   task automatic drive(input bit l, input bit r, input bit h);
      bus.leftSwitch   = l;
      bus.rightSwitch  = r;
      bus.hazardSwitch = h;
   endtask

   task automatic settle(input int n);
      drive(1'b0, 1'b0, 1'b0);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      logic [4:0] obs;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      obs = obs_vec();
      n_vec++;
      if (obs !== exp_vec(0, 1'b0)) begin
         n_err++;
         $display("FAIL reset_state: got %b want %b", obs, exp_vec(0, 1'b0));
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_glitch();
      logic [4:0] obs;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 3) drive(1'b0, 1'b0, 1'b0);
         obs = obs_vec();
         n_vec++;
         if (obs !== exp_vec(0, 1'b0)) begin
            n_err++;
            $display("FAIL glitch c=%0d: got %b want %b", c, obs, exp_vec(0, 1'b0));
         end
      end
      settle(5);
   endtask

   task automatic test_hold();
      logic [4:0] obs;
      logic [4:0] want;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         want = exp_vec((c >= 7) ? 1 : 0, c == 7);
         obs  = obs_vec();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL hold edge=%0d: got %b want %b", c, obs, want);
         end
      end
      settle(25);
   endtask

   task automatic test_short_tap();
      logic [4:0] obs;
      logic [4:0] want;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 5) drive(1'b0, 1'b0, 1'b0);
         want = exp_vec((c >= 7 && c <= 14) ? 1 : 0, (c == 7) || (c == 15));
         obs  = obs_vec();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL short_tap edge=%0d: got %b want %b", c, obs, want);
         end
      end
      settle(10);
   endtask

   task automatic test_preempt();
      logic [4:0] obs;
      logic [4:0] want;
      int         st;
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 9) drive(1'b1, 1'b0, 1'b1);
         st   = (c < 7) ? 0 : ((c < 16) ? 1 : 3);
         want = exp_vec(st, (c == 7) || (c == 16));
         obs  = obs_vec();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL preempt edge=%0d: got %b want %b", c, obs, want);
         end
      end
      settle(30);
   endtask

   task automatic test_conflict_swap();
      logic [4:0] obs;
      logic [4:0] want;
      drive(1'b1, 1'b1, 1'b0);
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         obs = obs_vec();
         n_vec++;
         if (obs !== exp_vec(0, 1'b0)) begin
            n_err++;
            $display("FAIL conflict edge=%0d: got %b want %b", c, obs, exp_vec(0, 1'b0));
         end
      end
      drive(1'b0, 1'b1, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         want = exp_vec((c >= 7) ? 2 : 0, c == 7);
         obs  = obs_vec();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL right_hold edge=%0d: got %b want %b", c, obs, want);
         end
      end
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         want = exp_vec((c >= 7) ? 1 : 2, c == 7);
         obs  = obs_vec();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL direct_swap edge=%0d: got %b want %b", c, obs, want);
         end
      end
      settle(25);
   endtask

   task automatic test_async_reset();
      logic [4:0] obs;
      logic [4:0] want;
      drive(1'b0, 1'b0, 1'b1);
      repeat (8) @(negedge clk);
      obs = obs_vec();
      n_vec++;
      if (obs !== exp_vec(3, 1'b0)) begin
         n_err++;
         $display("FAIL hazard_before_reset: got %b want %b", obs, exp_vec(3, 1'b0));
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      obs = obs_vec();
      n_vec++;
      if (obs !== exp_vec(0, 1'b0)) begin
         n_err++;
         $display("FAIL async_reset: got %b want %b", obs, exp_vec(0, 1'b0));
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         want = exp_vec((c >= 7) ? 3 : 0, c == 7);
         obs  = obs_vec();
         n_vec++;
         if (obs !== want) begin
            n_err++;
            $display("FAIL reentry edge=%0d: got %b want %b", c, obs, want);
         end
      end
      settle(30);
   endtask

   // ---------------- randomized run against the model ----------------
   task automatic test_random();
      logic [4:0] obs;
      logic [4:0] want;
      int         len;
      for (int p = 0; p < 300; p++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 39) == 0) begin
            @(posedge clk);
            #2 reset = 1'b0;
            #1;
            obs  = obs_vec();
            want = exp_vec(m_state, m_mc);
            n_vec++;
            if (obs !== want) begin
               n_err++;
               $display("FAIL random_reset p=%0d: got %b want %b", p, obs, want);
            end
            @(negedge clk);
            reset = 1'b1;
         end
         len = $urandom_range(1, 14);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            obs  = obs_vec();
            want = exp_vec(m_state, m_mc);
            n_vec++;
            if (obs !== want) begin
               n_err++;
               $display("FAIL random p=%0d c=%0d: got %b want %b", p, c, obs, want);
            end
         end
      end
      settle(30);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      test_reset();
      test_glitch();
      test_hold();
      test_short_tap();
      test_preempt();
      test_conflict_swap();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
